game_end_fsm: RTL

GAME_END_FSM -- requirements
Module: game_end_fsm

---
 rtl/game_pkg.sv | 24 ++
 rtl/board_scanner.sv | 40 ++++
 rtl/game_end_fsm.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared constants and types for the battleship end-of-game checker: cell codes,
// winner ids, FSM state codes and the board type at the default 5x5 geometry.
package game_pkg;

  localparam int BOARD_N   = 5;
  localparam int CELL_BITS = 3;

  localparam logic [CELL_BITS-1:0] CELL_EMPTY = 3'd0;
  localparam logic [CELL_BITS-1:0] CELL_SHIP  = 3'd1;
  localparam logic [CELL_BITS-1:0] CELL_HIT   = 3'd2;
  localparam logic [CELL_BITS-1:0] CELL_MISS  = 3'd3;

  localparam logic [1:0] WIN_NONE   = 2'd0;
  localparam logic [1:0] WIN_PLAYER = 2'd1;
  localparam logic [1:0] WIN_PC     = 2'd2;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SCAN   = 2'd1;
  localparam logic [1:0] ST_DECIDE = 2'd2;
  localparam logic [1:0] ST_WON    = 2'd3;

  typedef logic [CELL_BITS-1:0] board_t [0:BOARD_N-1][0:BOARD_N-1];

endpackage

// File: rtl/board_scanner.sv
// Per-board tally: counts ship cells and hit cells presented one per cycle while
// enabled; cleared by reset or by the start of a new check.
module board_scanner
  import game_pkg::*;
#(
  parameter int CELL_W = 3,
  parameter int CNT_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clr,
  input  logic              i_en,
  input  logic [CELL_W-1:0] i_cell,
  output logic [CNT_W-1:0]  o_ships,
  output logic [CNT_W-1:0]  o_hits
);

  logic [CNT_W-1:0] r_ships;
  logic [CNT_W-1:0] r_hits;
  logic             w_is_ship;
  logic             w_is_hit;

  // Codes 4..7 match neither constant, so they fall through as empty.
  assign w_is_ship = (i_cell == CELL_W'(CELL_SHIP));
  assign w_is_hit  = (i_cell == CELL_W'(CELL_HIT));

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_ships <= '0;
      r_hits  <= '0;
    end else if (i_en) begin
      if (w_is_ship) r_ships <= r_ships + CNT_W'(1);
      if (w_is_hit)  r_hits  <= r_hits + CNT_W'(1);
    end
  end

  assign o_ships = r_ships;
  assign o_hits  = r_hits;

endmodule

// File: rtl/game_end_fsm.sv
// End-of-game checker: snapshots both fleet boards on start, scans them cell by cell
// and latches a winner. Define TURN_LIMIT_EN to also end the game after TURN_LIMIT shots.
//
// state  | meaning
// IDLE   | waiting for start; snapshot taken and counters cleared on start
// SCAN   | one cell index per cycle on both snapshots, row-major
// DECIDE | evaluate defeat rules, update ships_left, pulse done
// WON    | winner latched; only rst leaves
module game_end_fsm
  import game_pkg::*;
#(
  parameter int N          = 5,
  parameter int CELL_W     = 3,
  parameter int TURN_LIMIT = 40
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CELL_W-1:0] board_player [0:N-1][0:N-1],
  input  logic [CELL_W-1:0] board_pc     [0:N-1][0:N-1],
  output logic              busy,
  output logic              done,
  output logic [1:0]        win_id,
  output logic              win_en,
  output logic [4:0]        ships_left_player,
  output logic [4:0]        ships_left_pc
);

  localparam int CNT_W = $clog2(N*N+1);
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  logic [1:0]        r_state;
  logic [IDX_W-1:0]  r_row;
  logic [IDX_W-1:0]  r_col;
  logic [CELL_W-1:0] r_snap_pl [0:N-1][0:N-1];
  logic [CELL_W-1:0] r_snap_pc [0:N-1][0:N-1];
  logic              r_done;
  logic [1:0]        r_win_id;
  logic              r_win_en;
  logic [4:0]        r_ships_left_pl;
  logic [4:0]        r_ships_left_pc;

  logic              w_accept;
  logic              w_scan_en;
  logic              w_last;
  logic [CNT_W-1:0]  w_ships_pl;
  logic [CNT_W-1:0]  w_hits_pl;
  logic [CNT_W-1:0]  w_ships_pc;
  logic [CNT_W-1:0]  w_hits_pc;
  logic              w_def_pl;
  logic              w_def_pc;
  logic [1:0]        w_next_win;

  assign w_accept  = (r_state == ST_IDLE) && start;
  assign w_scan_en = (r_state == ST_SCAN);
  assign w_last    = (r_row == IDX_W'(N-1)) && (r_col == IDX_W'(N-1));

  always_ff @(posedge clk) begin
    if (w_accept && !rst) begin
      r_snap_pl <= board_player;
      r_snap_pc <= board_pc;
    end
  end

  board_scanner #(.CELL_W(CELL_W), .CNT_W(CNT_W)) u_scan_pl (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_accept),
    .i_en    (w_scan_en),
    .i_cell  (r_snap_pl[r_row][r_col]),
    .o_ships (w_ships_pl),
    .o_hits  (w_hits_pl)
  );

  board_scanner #(.CELL_W(CELL_W), .CNT_W(CNT_W)) u_scan_pc (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_accept),
    .i_en    (w_scan_en),
    .i_cell  (r_snap_pc[r_row][r_col]),
    .o_ships (w_ships_pc),
    .o_hits  (w_hits_pc)
  );

  // An untouched board has no hits, so it can never count as sunk.
  assign w_def_pl = (w_ships_pl == '0) && (w_hits_pl != '0);
  assign w_def_pc = (w_ships_pc == '0) && (w_hits_pc != '0);

`ifdef TURN_LIMIT_EN
  localparam int TURN_W = $clog2(TURN_LIMIT+2);

  logic [TURN_W-1:0] r_turns;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_turns <= '0;
    end else if (w_accept && (r_turns != {TURN_W{1'b1}})) begin
      r_turns <= r_turns + TURN_W'(1);
    end
  end

  // Hits recorded on the PC board are the player's hits, and vice versa.
  always_comb begin
    w_next_win = WIN_NONE;
    if (w_def_pc)
      w_next_win = WIN_PLAYER;
    else if (w_def_pl)
      w_next_win = WIN_PC;
    else if (r_turns == TURN_W'(TURN_LIMIT))
      w_next_win = (w_hits_pc >= w_hits_pl) ? WIN_PLAYER : WIN_PC;
  end
`else
  logic w_unused_turn_limit;
  assign w_unused_turn_limit = (TURN_LIMIT != 0);

  always_comb begin
    w_next_win = WIN_NONE;
    if (w_def_pc)
      w_next_win = WIN_PLAYER;
    else if (w_def_pl)
      w_next_win = WIN_PC;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= ST_IDLE;
      r_row           <= '0;
      r_col           <= '0;
      r_done          <= 1'b0;
      r_win_id        <= WIN_NONE;
      r_win_en        <= 1'b0;
      r_ships_left_pl <= '0;
      r_ships_left_pc <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_SCAN;
            r_row   <= '0;
            r_col   <= '0;
          end
        end
        ST_SCAN: begin
          if (w_last) begin
            r_state <= ST_DECIDE;
          end else if (r_col == IDX_W'(N-1)) begin
            r_col <= '0;
            r_row <= r_row + IDX_W'(1);
          end else begin
            r_col <= r_col + IDX_W'(1);
          end
        end
        ST_DECIDE: begin
          r_done          <= 1'b1;
          r_win_id        <= w_next_win;
          r_win_en        <= (w_next_win != WIN_NONE);
          r_ships_left_pl <= 5'(w_ships_pl);
          r_ships_left_pc <= 5'(w_ships_pc);
          r_state         <= (w_next_win != WIN_NONE) ? ST_WON : ST_IDLE;
        end
        ST_WON: begin
          r_state <= ST_WON;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy              = (r_state == ST_SCAN) || (r_state == ST_DECIDE);
  assign done              = r_done;
  assign win_id            = r_win_id;
  assign win_en            = r_win_en;
  assign ships_left_player = r_ships_left_pl;
  assign ships_left_pc     = r_ships_left_pc;

endmodule
